// File: rtl/branch_predictor_unit.sv
//==============================================================================
// branch_predictor_unit: combinational next-PC predictor with a bimodal
// counter table and a circular return-address stack. `GSHARE_EN` enables
// global-history XOR indexing of the counter table.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module branch_predictor_unit #(
  parameter int         BHT_IDX_BITS = 5,
  parameter int         RAS_DEPTH    = 4,
  parameter logic [1:0] RST_CNT      = 2'b01,
  parameter int         GHR_BITS     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid,
  input  logic [31:0]                  fetch_pc,
  input  logic [31:0]                  fetch_inst,
  output logic [31:0]                  pred_pc,
  output logic                         pred_taken,
  output logic [1:0]                   pred_src,
  input  logic                         upd_valid,
  input  logic [31:0]                  upd_pc,
  input  logic                         upd_taken,
  input  logic                         flush,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PTR_W    = $clog2(RAS_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int BHT_SIZE = 2 ** BHT_IDX_BITS;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]        bht     [BHT_SIZE];
  logic [31:0]       ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [CNT_W-1:0]  ras_cnt;

  logic [BHT_IDX_BITS-1:0] fetch_idx;
  logic [BHT_IDX_BITS-1:0] upd_idx;

`ifdef GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  assign fetch_idx = fetch_pc[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(ghr);
  assign upd_idx   = upd_pc[BHT_IDX_BITS+1:2]   ^ BHT_IDX_BITS'(ghr);

  // History is architectural across flushes; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= {ghr[GHR_BITS-2:0], upd_taken};
    end
  end
`else
  assign fetch_idx = fetch_pc[BHT_IDX_BITS+1:2];
  assign upd_idx   = upd_pc[BHT_IDX_BITS+1:2];
`endif

  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^{upd_pc[31:BHT_IDX_BITS+2], upd_pc[1:0]};

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [31:0] j_imm;
  logic [31:0] i_imm;
  logic [31:0] b_imm;
  logic [31:0] seq_pc;
  logic [31:0] ras_top;
  logic [1:0]  fetch_cnt;
  logic        is_jal;
  logic        is_jalr;
  logic        is_branch;
  logic        is_ret;
  logic        do_push;
  logic        do_pop;

  assign opcode    = fetch_inst[6:0];
  assign rd        = fetch_inst[11:7];
  assign rs1       = fetch_inst[19:15];
  assign j_imm     = {{12{fetch_inst[31]}}, fetch_inst[19:12], fetch_inst[20],
                      fetch_inst[30:21], 1'b0};
  assign i_imm     = {{20{fetch_inst[31]}}, fetch_inst[31:20]};
  assign b_imm     = {{20{fetch_inst[31]}}, fetch_inst[7], fetch_inst[30:25],
                      fetch_inst[11:8], 1'b0};
  assign seq_pc    = fetch_pc + 32'd4;
  assign ras_top   = ras_mem[ras_ptr];
  assign fetch_cnt = bht[fetch_idx];

  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_ret    = is_jalr && (rs1 == 5'd1) && (rd == 5'd0);

  // A link to x1 always counts as a call, which wins over any ret decode.
  assign do_push   = fetch_valid && (is_jal || is_jalr) && (rd == 5'd1);
  assign do_pop    = fetch_valid && is_ret && !do_push && (ras_cnt != '0);

  always_comb begin
    pred_pc  = seq_pc;
    pred_src = 2'd0;
    if (fetch_valid) begin
      if (is_jal) begin
        pred_pc  = fetch_pc + j_imm;
        pred_src = 2'd1;
      end else if (is_ret && (ras_cnt != '0)) begin
        pred_pc  = (ras_top + i_imm) & ~32'd1;
        pred_src = 2'd2;
      end else if (is_branch && fetch_cnt[1]) begin
        pred_pc  = fetch_pc + b_imm;
        pred_src = 2'd3;
      end
    end
  end

  assign pred_taken = (pred_src != 2'd0);
  assign ras_count  = ras_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_SIZE; i++) begin
        bht[i] <= RST_CNT;
      end
    end else if (upd_valid) begin
      if (upd_taken && (bht[upd_idx] != 2'b11)) begin
        bht[upd_idx] <= bht[upd_idx] + 2'd1;
      end else if (!upd_taken && (bht[upd_idx] != 2'b00)) begin
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  // Stack storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) begin
      ras_mem[ras_ptr + PTR_W'(1)] <= seq_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != RAS_FULL) begin
        ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end else if (do_pop) begin
      ras_ptr <= ras_ptr - PTR_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_unit.sv
//==============================================================================
// tb_branch_predictor_unit: vector table plus hand sequences, checked through
// an expected-result queue.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_branch_predictor_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BEQ   = 32'h0200_0063; // beq x0,x0,+0x20
  localparam logic [31:0] BEQM4 = 32'hFE00_0EE3; // beq x0,x0,-4
  localparam logic [31:0] JAL1  = 32'h0400_00EF; // jal x1,+0x40
  localparam logic [31:0] RET   = 32'h0000_8067; // jalr x0,0(x1)
  localparam logic [31:0] RET3  = 32'h0030_8067; // jalr x0,3(x1)
  localparam logic [31:0] JALR2 = 32'h0001_0067; // jalr x0,0(x2)

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [1:0]  pred_src;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        flush;
  logic [2:0]  ras_count;

  branch_predictor_unit #(
    .BHT_IDX_BITS(5),
    .RAS_DEPTH   (4),
    .RST_CNT     (2'b01),
    .GHR_BITS    (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_valid(fetch_valid),
    .fetch_pc   (fetch_pc),
    .fetch_inst (fetch_inst),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .pred_src   (pred_src),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .flush      (flush),
    .ras_count  (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        fv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        fl;
    logic [31:0] epc;
    logic [1:0]  esrc;
    logic [2:0]  ecnt;
    string       tag;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  src;
    logic [2:0]  cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] epc, input logic [1:0] esrc,
                              input logic [2:0] ecnt, input string tag);
    vec_t v;
    v.rn = 1'b1; v.fv = fv; v.pc = pc; v.inst = inst; v.uv = uv; v.upc = upc;
    v.ut = ut; v.fl = 1'b0; v.epc = epc; v.esrc = esrc; v.ecnt = ecnt; v.tag = tag;
    return v;
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, what, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    rst_n       = v.rn;
    fetch_valid = v.fv;
    fetch_pc    = v.pc;
    fetch_inst  = v.inst;
    upd_valid   = v.uv;
    upd_pc      = v.upc;
    upd_taken   = v.ut;
    flush       = v.fl;
    e.pc = v.epc; e.src = v.esrc; e.cnt = v.ecnt; e.tag = v.tag;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk(got.tag, "pred_pc",    pred_pc,           got.pc);
    chk(got.tag, "pred_src",   {30'd0, pred_src}, {30'd0, got.src});
    chk(got.tag, "pred_taken", {31'd0, pred_taken}, {31'd0, (got.src != 2'd0)});
    chk(got.tag, "ras_count",  {29'd0, ras_count}, {29'd0, got.cnt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [31:0] ret_exp [4];

    // Branch training, saturation at both ends, and same-cycle read/write.
    vecs.push_back(mk(0, 32'h100, NOP,   0, 0, 0,      32'h104, 0, 0, "rst_state"));
    vecs.push_back(mk(1, 32'h100, BEQ,   0, 0, 0,      32'h104, 0, 0, "beq_cold"));
    vecs.push_back(mk(0, 32'h100, NOP,   1, 32'h100, 1, 32'h104, 0, 0, "train1"));
    vecs.push_back(mk(1, 32'h100, BEQ,   0, 0, 0,      32'h120, 3, 0, "beq_taken"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 1, 32'h120, 3, 0, "sat_up1"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 1, 32'h120, 3, 0, "sat_up2"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 1, 32'h120, 3, 0, "sat_up3"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 1, 32'h120, 3, 0, "sat_up4"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 1, 32'h120, 3, 0, "sat_up5"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 0, 32'h120, 3, 0, "sat_dn1"));
    vecs.push_back(mk(1, 32'h100, BEQ,   0, 0, 0,      32'h120, 3, 0, "cnt2_hold"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 0, 32'h120, 3, 0, "sat_dn2"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 0, 32'h104, 0, 0, "sat_dn3"));
    vecs.push_back(mk(1, 32'h100, BEQ,   1, 32'h100, 0, 32'h104, 0, 0, "sat_floor"));
    vecs.push_back(mk(1, 32'h100, BEQ,   0, 0, 0,      32'h104, 0, 0, "floor_chk"));
    vecs.push_back(mk(1, 32'h184, BEQM4, 1, 32'h184, 1, 32'h188, 0, 0, "neg_train"));
    vecs.push_back(mk(1, 32'h184, BEQM4, 0, 0, 0,      32'h180, 3, 0, "neg_taken"));
    // Call/return basics, non-ret jalr, ret immediate, empty ret, fetch_valid gating.
    vecs.push_back(mk(1, 32'h200, JAL1,  0, 0, 0,      32'h240, 1, 0, "call"));
    vecs.push_back(mk(1, 32'h300, RET,   0, 0, 0,      32'h204, 2, 1, "ret"));
    vecs.push_back(mk(0, 32'h300, NOP,   0, 0, 0,      32'h304, 0, 0, "ret_popped"));
    vecs.push_back(mk(1, 32'h200, JAL1,  0, 0, 0,      32'h240, 1, 0, "call2"));
    vecs.push_back(mk(1, 32'h300, JALR2, 0, 0, 0,      32'h304, 0, 1, "jalr_x2"));
    vecs.push_back(mk(1, 32'h300, RET3,  0, 0, 0,      32'h206, 2, 1, "ret_imm"));
    vecs.push_back(mk(1, 32'h300, RET,   0, 0, 0,      32'h304, 0, 0, "ret_empty"));
    vecs.push_back(mk(0, 32'h300, JAL1,  0, 0, 0,      32'h304, 0, 0, "call_novalid"));
    vecs.push_back(mk(0, 32'h300, NOP,   0, 0, 0,      32'h304, 0, 0, "novalid_chk"));

    rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_inst = NOP;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Overflow: five calls into a four-deep stack, then drain past empty.
    for (int i = 0; i < 5; i++) begin
      apply(mk(1, 32'((i + 1) * 16), JAL1, 0, 0, 0,
               32'((i + 1) * 16 + 64), 1, 3'(i), "ovf_call"));
    end
    ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34; ret_exp[3] = 32'h24;
    for (int i = 0; i < 4; i++) begin
      apply(mk(1, 32'h400, RET, 0, 0, 0, ret_exp[i], 2, 3'(4 - i), "ovf_ret"));
    end
    apply(mk(1, 32'h400, RET, 0, 0, 0, 32'h404, 0, 0, "ovf_ret_empty"));

    // Flush with a simultaneous call; training in that cycle still lands.
    apply(mk(1, 32'h500, JAL1, 0, 0, 0, 32'h540, 1, 0, "fl_call1"));
    apply(mk(1, 32'h510, JAL1, 0, 0, 0, 32'h550, 1, 1, "fl_call2"));
    v = mk(1, 32'h520, JAL1, 1, 32'h184, 0, 32'h560, 1, 2, "fl_flush_call");
    v.fl = 1'b1;
    apply(v);
    apply(mk(1, 32'h600, RET,   0, 0, 0, 32'h604, 0, 0, "fl_ret_empty"));
    apply(mk(1, 32'h184, BEQM4, 0, 0, 0, 32'h188, 0, 0, "fl_train_kept"));

    // Reset mid-stream after training and three pushes.
    apply(mk(0, 32'h0,   NOP,  1, 32'h100, 1, 32'h4,   0, 0, "rs_train1"));
    apply(mk(0, 32'h0,   NOP,  1, 32'h100, 1, 32'h4,   0, 0, "rs_train2"));
    apply(mk(1, 32'h700, JAL1, 0, 0, 0,       32'h740, 1, 0, "rs_call1"));
    apply(mk(1, 32'h710, JAL1, 0, 0, 0,       32'h750, 1, 1, "rs_call2"));
    apply(mk(1, 32'h720, JAL1, 0, 0, 0,       32'h760, 1, 2, "rs_call3"));
    apply(mk(1, 32'h100, BEQ,  0, 0, 0,       32'h120, 3, 3, "rs_trained"));
    v = mk(0, 32'h0, NOP, 0, 0, 0, 32'h4, 0, 3, "rs_assert");
    v.rn = 1'b0;
    apply(v);
    apply(mk(1, 32'h100, BEQ,  0, 0, 0,       32'h104, 0, 0, "rs_beq_cleared"));
    apply(mk(1, 32'h800, RET,  0, 0, 0,       32'h804, 0, 0, "rs_ret_empty"));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
